// File: rtl/wb_merge_queue.sv
// wb_merge_queue
//   Write-back merge stage. Results from the fixed-latency ALU pipe (port A)
//   and the variable-latency MAC/load path (port B) are buffered in two
//   circular FIFOs. Each accepted entry is tagged with an arrival stamp. A
//   single write-back stream is emitted in global arrival order, so the later
//   of two writes to the same index always lands last.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   I_A_Valid/Index/Data     ALU result push
//   I_B_Valid/Index/Data     MAC/load result push
//   I_Stall                  downstream stall; blocks pops, queues still fill
//   O_A_Full, O_B_Full       queue holds DEPTH entries
//   O_WB_Valid/Index/Data    registered write-back; one write per valid cycle
//   O_Empty                  both queues empty and no write-back in flight
//   O_Overflow               sticky: a push hit a full queue (cleared by reset)
module wb_merge_queue #(
  parameter int DEPTH      = 4,
  parameter int WIDTH_IDX  = 8,
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_A_Valid,
  input  logic [WIDTH_IDX-1:0]  I_A_Index,
  input  logic [WIDTH_DATA-1:0] I_A_Data,
  input  logic                  I_B_Valid,
  input  logic [WIDTH_IDX-1:0]  I_B_Index,
  input  logic [WIDTH_DATA-1:0] I_B_Data,
  input  logic                  I_Stall,
  output logic                  O_A_Full,
  output logic                  O_B_Full,
  output logic                  O_WB_Valid,
  output logic [WIDTH_IDX-1:0]  O_WB_Index,
  output logic [WIDTH_DATA-1:0] O_WB_Data,
  output logic                  O_Empty,
  output logic                  O_Overflow
);

  localparam int PW          = $clog2(DEPTH);
  localparam int CW          = PW + 1;
  localparam int WIDTH_STAMP = PW + 2;

  // Queue 0 is port A, queue 1 is port B.
  logic [WIDTH_IDX-1:0]   mem_idx   [2][DEPTH];
  logic [WIDTH_DATA-1:0]  mem_data  [2][DEPTH];
  logic [WIDTH_STAMP-1:0] mem_stamp [2][DEPTH];

  logic [PW-1:0]          wr_ptr [2];
  logic [PW-1:0]          rd_ptr [2];
  logic [CW-1:0]          count  [2];
  logic [WIDTH_STAMP-1:0] stamp;

  logic                   in_valid [2];
  logic [WIDTH_IDX-1:0]   in_idx   [2];
  logic [WIDTH_DATA-1:0]  in_data  [2];
  logic [WIDTH_STAMP-1:0] in_stamp [2];

  logic                   full     [2];
  logic                   nonempty [2];
  logic                   push     [2];
  logic                   pop      [2];
  logic                   drop;
  logic [WIDTH_STAMP-1:0] stamp_next;

  logic [WIDTH_STAMP-1:0] head_stamp [2];
  logic [WIDTH_STAMP-1:0] stamp_diff;
  logic                   b_older;
  logic                   sel_b;
  logic                   pop_any;
  logic [WIDTH_IDX-1:0]   sel_idx;
  logic [WIDTH_DATA-1:0]  sel_data;

  always_comb begin
    in_valid[0] = I_A_Valid;
    in_idx[0]   = I_A_Index;
    in_data[0]  = I_A_Data;
    in_valid[1] = I_B_Valid;
    in_idx[1]   = I_B_Index;
    in_data[1]  = I_B_Data;
  end

  // Push acceptance looks at the pre-edge count, so a same-edge pop never
  // makes room for a push into a full queue.
  always_comb begin
    drop = 1'b0;
    for (int unsigned q = 0; q < 2; q++) begin
      full[q]     = (count[q] == CW'(DEPTH));
      nonempty[q] = (count[q] != '0);
      push[q]     = in_valid[q] && !full[q];
      drop        = drop | (in_valid[q] & full[q]);
    end
  end

  // Simultaneous pushes: A takes S, B takes S+1, so A counts as older.
  always_comb begin
    in_stamp[0] = stamp;
    in_stamp[1] = push[0] ? stamp + WIDTH_STAMP'(1) : stamp;
    stamp_next  = stamp + WIDTH_STAMP'(push[0]) + WIDTH_STAMP'(push[1]);
  end

  // Modular age compare: with at most 2*DEPTH live entries the stamp
  // difference stays within half the stamp range, so its MSB is the sign.
  always_comb begin
    head_stamp[0] = mem_stamp[0][rd_ptr[0]];
    head_stamp[1] = mem_stamp[1][rd_ptr[1]];
    stamp_diff    = head_stamp[0] - head_stamp[1];
    b_older       = !stamp_diff[WIDTH_STAMP-1] && (stamp_diff != '0);
    sel_b         = nonempty[1] && (!nonempty[0] || b_older);
    pop_any       = !I_Stall && (nonempty[0] || nonempty[1]);
    pop[0]        = pop_any && !sel_b;
    pop[1]        = pop_any && sel_b;
    sel_idx       = sel_b ? mem_idx[1][rd_ptr[1]]  : mem_idx[0][rd_ptr[0]];
    sel_data      = sel_b ? mem_data[1][rd_ptr[1]] : mem_data[0][rd_ptr[0]];
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clock) begin
    for (int unsigned q = 0; q < 2; q++) begin
      if (push[q]) begin
        mem_idx[q][wr_ptr[q]]   <= in_idx[q];
        mem_data[q][wr_ptr[q]]  <= in_data[q];
        mem_stamp[q][wr_ptr[q]] <= in_stamp[q];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned q = 0; q < 2; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        count[q]  <= '0;
      end
      stamp      <= '0;
      O_WB_Valid <= 1'b0;
      O_WB_Index <= '0;
      O_WB_Data  <= '0;
      O_Overflow <= 1'b0;
    end else begin
      for (int unsigned q = 0; q < 2; q++) begin
        if (push[q]) wr_ptr[q] <= wr_ptr[q] + PW'(1);
        if (pop[q])  rd_ptr[q] <= rd_ptr[q] + PW'(1);
        count[q] <= count[q] + CW'(push[q]) - CW'(pop[q]);
      end
      stamp      <= stamp_next;
      O_WB_Valid <= pop_any;
      if (pop_any) begin
        O_WB_Index <= sel_idx;
        O_WB_Data  <= sel_data;
      end
      if (drop) O_Overflow <= 1'b1;
    end
  end

  assign O_A_Full = full[0];
  assign O_B_Full = full[1];
  assign O_Empty  = !nonempty[0] && !nonempty[1] && !O_WB_Valid;

endmodule

// File: tb/tb_wb_merge_queue.sv
// Testbench for wb_merge_queue. The reference model treats the design as one
// global arrival-ordered list of accepted writes plus per-port occupancy;
// expected write-backs go into a scoreboard queue and a negedge monitor
// compares every valid write-back against its front.
module tb_wb_merge_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        I_A_Valid, I_B_Valid, I_Stall;
  logic [7:0]  I_A_Index, I_B_Index;
  logic [31:0] I_A_Data, I_B_Data;
  logic        O_A_Full, O_B_Full, O_WB_Valid, O_Empty, O_Overflow;
  logic [7:0]  O_WB_Index;
  logic [31:0] O_WB_Data;

  wb_merge_queue #(.DEPTH(DEPTH), .WIDTH_IDX(8), .WIDTH_DATA(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_A_Valid  (I_A_Valid),
    .I_A_Index  (I_A_Index),
    .I_A_Data   (I_A_Data),
    .I_B_Valid  (I_B_Valid),
    .I_B_Index  (I_B_Index),
    .I_B_Data   (I_B_Data),
    .I_Stall    (I_Stall),
    .O_A_Full   (O_A_Full),
    .O_B_Full   (O_B_Full),
    .O_WB_Valid (O_WB_Valid),
    .O_WB_Index (O_WB_Index),
    .O_WB_Data  (O_WB_Data),
    .O_Empty    (O_Empty),
    .O_Overflow (O_Overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int ntests = 0;
  int nfail  = 0;

  // Reference model state.
  logic [39:0] sb[$];       // expected write-backs {index, data}, arrival order
  bit          pending[$];  // source port of each not-yet-popped entry, arrival order
  int          cnt_a = 0;
  int          cnt_b = 0;
  bit          ovf   = 1'b0;
  bit          exp_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid write-back must be the oldest outstanding write.
  always @(negedge clock) begin
    if (reset && O_WB_Valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {24'd0, O_WB_Index, O_WB_Data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = sb.pop_front();
        chk("wb_entry", {24'd0, O_WB_Index, O_WB_Data}, {24'd0, e});
      end
    end
  end

  // One clock cycle: drive inputs, advance the model, take the edge, check flags.
  task automatic step(input bit av, input logic [7:0] ai, input logic [31:0] ad,
                      input bit bv, input logic [7:0] bi, input logic [31:0] bd,
                      input bit st);
    bit acc_a, acc_b;
    I_A_Valid = av; I_A_Index = ai; I_A_Data = ad;
    I_B_Valid = bv; I_B_Index = bi; I_B_Data = bd;
    I_Stall   = st;
    acc_a = av && (cnt_a < DEPTH);
    acc_b = bv && (cnt_b < DEPTH);
    if ((av && !acc_a) || (bv && !acc_b)) ovf = 1'b1;
    // Only entries present before this edge are eligible; the oldest leaves.
    if (!st && pending.size() > 0) begin
      if (pending.pop_front() == 1'b0) cnt_a--; else cnt_b--;
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    if (acc_a) begin pending.push_back(1'b0); sb.push_back({ai, ad}); cnt_a++; end
    if (acc_b) begin pending.push_back(1'b1); sb.push_back({bi, bd}); cnt_b++; end
    @(posedge clock);
    #1;
    chk("wb_valid", {63'd0, O_WB_Valid}, {63'd0, exp_v});
    chk("a_full",   {63'd0, O_A_Full},   {63'd0, cnt_a == DEPTH});
    chk("b_full",   {63'd0, O_B_Full},   {63'd0, cnt_b == DEPTH});
    chk("overflow", {63'd0, O_Overflow}, {63'd0, ovf});
    chk("empty",    {63'd0, O_Empty},    {63'd0, (cnt_a == 0) && (cnt_b == 0) && !exp_v});
  endtask

  task automatic idle(input bit st);
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0, st);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (pending.size() == 0 && !exp_v) break;
      idle(1'b0);
    end
    idle(1'b0);
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"},    {63'd0, O_WB_Valid}, 64'd0);
    chk({tag, "_index"},    {56'd0, O_WB_Index}, 64'd0);
    chk({tag, "_data"},     {32'd0, O_WB_Data},  64'd0);
    chk({tag, "_afull"},    {63'd0, O_A_Full},   64'd0);
    chk({tag, "_bfull"},    {63'd0, O_B_Full},   64'd0);
    chk({tag, "_empty"},    {63'd0, O_Empty},    64'd1);
    chk({tag, "_overflow"}, {63'd0, O_Overflow}, 64'd0);
  endtask

  initial begin
    I_A_Valid = 0; I_A_Index = '0; I_A_Data = '0;
    I_B_Valid = 0; I_B_Index = '0; I_B_Data = '0;
    I_Stall = 0;
    reset = 1'b0;
    #2;
    check_reset_values("rst");
    #5 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single A push, emitted next cycle, then empty.
    step(1'b1, 8'd5, 32'hDEAD, 1'b0, 8'd0, 32'd0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Simultaneous A/B to the same index: A first.
    step(1'b1, 8'd3, 32'h11, 1'b1, 8'd3, 32'h22, 1'b0);
    drain();

    // B then four A pushes: B, A, A, A, A back to back.
    step(1'b0, 8'd0, 32'd0, 1'b1, 8'd9, 32'hB0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 32'hA0 + 32'(i), 1'b0, 8'd0, 32'd0, 1'b0);
    drain();

    // Stall while filling A; fifth push overflows and is dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(20 + i), 32'hC00 + 32'(i), 1'b0, 8'd0, 32'd0, 1'b1);
    idle(1'b1);
    drain();

    // Alternating A/B pushes across several stamp wraps, random stalls.
    for (int i = 0; i < 48; i++) begin
      if (i % 2 == 0)
        step(1'b1, 8'($urandom_range(0, 3)), $urandom, 1'b0, 8'd0, 32'd0, $urandom_range(0, 3) == 0);
      else
        step(1'b0, 8'd0, 32'd0, 1'b1, 8'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0);
    end
    drain();

    // Fully random traffic including overflow pressure.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 55, 8'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 30);
    end
    drain();

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(40 + i), 32'hE0 + 32'(i), 1'b0, 8'd0, 32'd0, 1'b1);
    I_A_Valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    sb.delete();
    pending.delete();
    cnt_a = 0; cnt_b = 0; ovf = 1'b0; exp_v = 1'b0;
    #1 reset = 1'b1;
    step(1'b0, 8'd0, 32'd0, 1'b1, 8'd77, 32'h7777, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
